// File: rtl/fu_mem_queue.sv
// Non-blocking memory functional unit: an in-order load/store queue in front of the d-cache.
// One cache request is in flight at a time, issued from the head; results are broadcast on the CDB.
module fu_mem_queue #(
  parameter int DEPTH     = 4,
  parameter int LINE_W    = 256,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  // issue packet
  input  logic                 pkt_valid_i,
  input  logic [ROB_IDX_W-1:0] pkt_rob_tag_i,
  input  logic                 pkt_ls_i,        // 1 = store, 0 = load
  input  logic [2:0]           pkt_funct3_i,
  input  logic [31:0]          pkt_rs1_v_i,
  input  logic [31:0]          pkt_rs2_v_i,
  input  logic [31:0]          pkt_offset_i,
  output logic                 backpressure_o,
  input  logic [ROB_IDX_W-1:0] rob_head_tag_i,
  // CDB broadcast
  output logic                 cdb_valid_o,
  output logic [ROB_IDX_W-1:0] cdb_rob_tag_o,
  output logic                 cdb_ls_o,
  output logic [31:0]          cdb_data_o,
  output logic [31:0]          cdb_rs1_data_o,
  output logic [31:0]          cdb_rs2_data_o,
  output logic [31:0]          cdb_rvfi_mem_addr_o,
  output logic [3:0]           cdb_rvfi_rmask_o,
  output logic [3:0]           cdb_rvfi_wmask_o,
  output logic [31:0]          cdb_rvfi_rdata_o,
  output logic [31:0]          cdb_rvfi_wdata_o,
  output logic [31:0]          cdb_rvfi_rd_wdata_o,
  // d-cache
  output logic [31:0]          mem_addr_o,
  output logic [3:0]           mem_rmask_o,
  output logic [3:0]           mem_wmask_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [LINE_W-1:0]    rdata_i,
  input  logic                 d_cache_resp_i
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int NWORDS = LINE_W / 32;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_tag;
    logic                 ls;
    logic [2:0]           funct3;
    logic [31:0]          ea;
    logic [31:0]          rs1;
    logic [31:0]          rs2;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_e;

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   byte_mask = 4'b0001 << off;
      2'b01:   byte_mask = 4'b0011 << off;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [1:0] off,
                                              input logic [31:0] rs2);
    case (funct3[1:0])
      2'b00:   store_lanes = {24'b0, rs2[7:0]} << {off, 3'b000};
      2'b01:   store_lanes = {16'b0, rs2[15:0]} << {off, 3'b000};
      default: store_lanes = rs2;
    endcase
  endfunction

  function automatic logic may_issue(input entry_t ent, input logic [ROB_IDX_W-1:0] head_tag);
    may_issue = !ent.ls || (ent.rob_tag == head_tag);
  endfunction

  entry_t               q_mem [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d, head_nxt;
  logic [PTR_W:0]       count_q, count_d;
  state_e               state_q, state_d;

  // The in-flight request is latched at launch so DRAIN can hold it after the queue is cleared.
  logic [31:0]          req_addr_q, req_addr_d;
  logic [31:0]          req_wdata_q, req_wdata_d;
  logic [3:0]           req_rmask_q, req_rmask_d;
  logic [3:0]           req_wmask_q, req_wmask_d;

  entry_t               head_ent, next_ent, launch_ent, enq_ent;
  logic                 head_ok, next_ok, launch;
  logic                 pop, enq, active;

  assign head_nxt = head_q + PTR_W'(1);
  assign head_ent = q_mem[head_q];
  assign next_ent = q_mem[head_nxt];
  assign head_ok  = (count_q != '0) && may_issue(head_ent, rob_head_tag_i);
  assign next_ok  = (count_q > (PTR_W+1)'(1)) && may_issue(next_ent, rob_head_tag_i);

  assign backpressure_o = (count_q == (PTR_W+1)'(DEPTH));
  assign pop            = (state_q == REQ) && d_cache_resp_i && !flush_i;
  // A pop frees the slot in the same cycle, so a full queue still accepts a packet then.
  assign enq            = pkt_valid_i && !flush_i && (!backpressure_o || pop);

  always_comb begin
    enq_ent         = '0;
    enq_ent.rob_tag = pkt_rob_tag_i;
    enq_ent.ls      = pkt_ls_i;
    enq_ent.funct3  = pkt_funct3_i;
    enq_ent.ea      = pkt_rs1_v_i + pkt_offset_i;
    enq_ent.rs1     = pkt_rs1_v_i;
    enq_ent.rs2     = pkt_rs2_v_i;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    launch_ent = head_ent;
    case (state_q)
      IDLE: begin
        if (!flush_i && head_ok) begin
          state_d = REQ;
          launch  = 1'b1;
        end
      end
      REQ: begin
        if (flush_i) begin
          state_d = d_cache_resp_i ? IDLE : DRAIN;
        end else if (d_cache_resp_i) begin
          if (next_ok) begin
            launch     = 1'b1;
            launch_ent = next_ent;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (d_cache_resp_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_addr_d  = req_addr_q;
    req_rmask_d = req_rmask_q;
    req_wmask_d = req_wmask_q;
    req_wdata_d = req_wdata_q;
    if (launch) begin
      req_addr_d = {launch_ent.ea[31:2], 2'b00};
      if (launch_ent.ls) begin
        req_rmask_d = 4'b0000;
        req_wmask_d = byte_mask(launch_ent.funct3, launch_ent.ea[1:0]);
        req_wdata_d = store_lanes(launch_ent.funct3, launch_ent.ea[1:0], launch_ent.rs2);
      end else begin
        req_rmask_d = byte_mask(launch_ent.funct3, launch_ent.ea[1:0]);
        req_wmask_d = 4'b0000;
        req_wdata_d = '0;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (pop) head_d = head_nxt;
      case ({enq, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      req_addr_q  <= '0;
      req_rmask_q <= '0;
      req_wmask_q <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      req_addr_q  <= req_addr_d;
      req_rmask_q <= req_rmask_d;
      req_wmask_q <= req_wmask_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone says which slots hold live entries.
  always_ff @(posedge clk) begin
    if (enq) q_mem[tail_q] <= enq_ent;
  end

  assign active      = (state_q == REQ) || (state_q == DRAIN);
  assign mem_addr_o  = active ? req_addr_q  : '0;
  assign mem_rmask_o = active ? req_rmask_q : '0;
  assign mem_wmask_o = active ? req_wmask_q : '0;
  assign mem_wdata_o = active ? req_wdata_q : '0;

  logic [WIDX_W-1:0] widx;
  logic [31:0]       line_word, shifted, load_val;

  always_comb begin
    widx      = (NWORDS > 1) ? head_ent.ea[WIDX_W+1:2] : '0;
    line_word = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (WIDX_W'(w) == widx) line_word = rdata_i[32*w +: 32];
    end
    shifted = line_word >> {head_ent.ea[1:0], 3'b000};
    case (head_ent.funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    cdb_valid_o         = pop;
    cdb_rob_tag_o       = '0;
    cdb_ls_o            = 1'b0;
    cdb_data_o          = '0;
    cdb_rs1_data_o      = '0;
    cdb_rs2_data_o      = '0;
    cdb_rvfi_mem_addr_o = '0;
    cdb_rvfi_rmask_o    = '0;
    cdb_rvfi_wmask_o    = '0;
    cdb_rvfi_rdata_o    = '0;
    cdb_rvfi_wdata_o    = '0;
    cdb_rvfi_rd_wdata_o = '0;
    if (pop) begin
      cdb_rob_tag_o       = head_ent.rob_tag;
      cdb_ls_o            = head_ent.ls;
      cdb_data_o          = head_ent.ls ? 32'b0 : load_val;
      cdb_rs1_data_o      = head_ent.rs1;
      cdb_rs2_data_o      = head_ent.rs2;
      cdb_rvfi_mem_addr_o = req_addr_q;
      cdb_rvfi_rmask_o    = req_rmask_q;
      cdb_rvfi_wmask_o    = req_wmask_q;
      cdb_rvfi_rdata_o    = head_ent.ls ? 32'b0 : line_word;
      cdb_rvfi_wdata_o    = req_wdata_q;
      cdb_rvfi_rd_wdata_o = head_ent.ls ? 32'b0 : load_val;
    end
  end

endmodule
